// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : RV32I opcode/funct constants and ALU op codes shared by the
//                instruction encoder and the decoder. Also holds the encoder
//                state type and the bundle legality and encoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0]  OPC_R    = 7'h33;
    localparam logic [6:0]  OPC_I    = 7'h13;
    localparam logic [6:0]  F7_ADD   = 7'h00;
    localparam logic [6:0]  F7_SUB   = 7'h20;
    localparam logic [2:0]  F3_ADD   = 3'b000;

    localparam logic [3:0]  ALU_ADD  = 4'b0010;
    localparam logic [3:0]  ALU_SUB  = 4'b0100;
    localparam logic [3:0]  ALU_NOP  = 4'b1111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } enc_state_t;

    // An immediate fits the I-type field when bits 31..11 are a pure sign extension.
    function automatic logic imm12_fits(input logic [31:0] imm);
        return (imm[31:11] == '0) || (imm[31:11] == '1);
    endfunction

    function automatic logic bundle_legal(input logic [3:0]  alu_op,
                                          input logic        is_imm,
                                          input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        case (alu_op)
            ALU_ADD: ok = !is_imm || imm12_fits(imm);
            ALU_SUB: ok = !is_imm;
            ALU_NOP: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only meaningful for legal bundles; illegal ones never reach the FIFO.
    function automatic logic [31:0] encode(input logic [3:0]  alu_op,
                                           input logic        is_imm,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  rs1,
                                           input logic [4:0]  rs2,
                                           input logic [31:0] imm);
        logic [31:0] word;
        word = NOP_WORD;
        case (alu_op)
            ALU_ADD: word = is_imm ? {imm[11:0], rs1, F3_ADD, rd, OPC_I}
                                   : {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_R};
            ALU_SUB: word = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_R};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, power-of-two depth, head word visible on
//                head_o whenever not empty. Push when full and pop when empty
//                are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset discards all stored entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array, written on push only.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder
//  Description : Encodes decoded instruction field bundles into RV32I words
//                (ADD/SUB/ADDI/NOP), buffers them in a FIFO and streams them
//                into instruction memory over a ready/valid write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic              in_is_imm,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_wr_en,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [15:0]       words_written,
    output logic              busy,
    output logic              done
);

    enc_state_t        state_q, state_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [15:0]       words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              clear_stats;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       enc_word;
    logic [31:0]       head_word;

    assign in_ready = (state_q == RUN) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign legal    = bundle_legal(in_alu_op, in_is_imm, in_imm);
    assign enc_word = encode(in_alu_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm);
    assign push     = accept && legal;
    assign pop      = mem_wr_en && mem_wr_ready;

    assign mem_wr_en     = !fifo_empty;
    assign mem_wr_data   = head_word;
    assign mem_wr_addr   = addr_q;
    assign err           = err_q;
    assign err_count     = err_count_q;
    assign words_written = words_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .wr_data_i (enc_word),
        .pop_i     (pop),
        .head_o    (head_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Program sequencing: start opens a program, flush drains it, done marks the end.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        clear_stats = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    clear_stats = 1'b1;
                end
            end
            RUN: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write address, completed-write count and dropped-bundle statistics.
    always_comb begin
        addr_d      = addr_q;
        words_d     = words_q;
        err_count_d = err_count_q;
        err_d       = accept && !legal;
        if (clear_stats) begin
            addr_d      = BASE_ADDR;
            words_d     = '0;
            err_count_d = '0;
        end else begin
            if (pop) begin
                addr_d  = addr_q + ADDR_W'(4);
                words_d = words_q + 16'd1;
            end
            if (err_d && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            words_q     <= '0;
            addr_q      <= BASE_ADDR;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Producer-side counterpart of the instruction decoder. It accepts decoded instruction fields (ALU op, register numbers, immediate), encodes them into 32-bit RV32I words (R-type ADD/SUB, I-type ADDI, NOP) and buffers them in a small FIFO. It then writes them sequentially into instruction memory through a ready/valid write port. It is used by the program loader and by self-test to build instruction streams the core's decoder consumes.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_W, 32, instruction memory byte-address width
BASE_ADDR, 0, first write address after start

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin a new program (IDLE->RUN), address <= BASE_ADDR
flush  input  1  pulse: stop accepting, drain FIFO (RUN->DRAIN)
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
in_alu_op  input  4  4'b0010 ADD, 4'b0100 SUB, 4'b1111 NOP; others illegal
in_is_imm  input  1  1 = I-type (ADDI), 0 = R-type
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2 (ignored when in_is_imm)
in_imm  input  32  immediate (I-type only)
mem_wr_en  output  1  write request valid
mem_wr_ready  input  1  memory accepts write this cycle
mem_wr_addr  output  ADDR_W  byte address of write
mem_wr_data  output  32  encoded instruction
err  output  1  1-cycle pulse: illegal bundle dropped
err_count  output  8  saturating count of dropped bundles since start
words_written  output  16  completed writes since start (wraps)
busy  output  1  state != IDLE
done  output  1  1-cycle pulse when DRAIN completes

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO emptied, mem_wr_addr=BASE_ADDR. in_ready, mem_wr_en, err, done and busy are 0; err_count and words_written are 0. Reset mid-operation discards all buffered words.
- FSM: IDLE --start--> RUN. RUN --flush--> DRAIN. DRAIN --FIFO empty and no write pending--> IDLE with done=1 for one cycle. start is ignored outside IDLE; flush is ignored outside RUN. start in IDLE clears err_count and words_written and loads mem_wr_addr=BASE_ADDR.
- in_ready = (state==RUN) && !fifo_full. The ready computation does not depend on a same-cycle pop.
- Accept = in_valid && in_ready. Encoding is combinational and the word is pushed at the accept edge. mem_wr_en is asserted the following cycle (latency 1).
- Encoding (funct3=000 for all):
  - ADD R: {7'h00, rs2, rs1, 3'b000, rd, 7'h33}.
  - SUB R: {7'h20, rs2, rs1, 3'b000, rd, 7'h33}.
  - ADDI: {imm[11:0], rs1, 3'b000, rd, 7'h13}.
  - NOP: 32'h00000013, regardless of other fields.
- Illegal bundles are accepted (handshake completes) but not pushed; err pulses one cycle after accept and err_count increments, saturating at 255. A bundle is illegal when:
  - alu_op is not ADD, SUB or NOP;
  - SUB with is_imm=1;
  - ADDI with imm not sign-representable in 12 bits (in_imm[31:11] not all equal).
- Write port: mem_wr_en = !fifo_empty; mem_wr_data = FIFO head. mem_wr_en and mem_wr_data are held stable until mem_wr_ready.
- On each completed write (mem_wr_en && mem_wr_ready): pop the FIFO, mem_wr_addr += 4 (wraps modulo 2^ADDR_W), words_written += 1 (wraps).
- Writes continue in RUN and DRAIN; they also complete in IDLE only if words remain, which cannot happen by construction.
- Simultaneous push and pop: both take effect and the occupancy is unchanged.
- flush with an empty FIFO: DRAIN for one cycle, then IDLE and done.

Decomposition:
- Shared package riscv_pkg:
  - OPC_R=7'h33, OPC_I=7'h13;
  - F7_ADD=7'h00, F7_SUB=7'h20, F3_ADD=3'b000;
  - ALU_ADD=4'b0010, ALU_SUB=4'b0100, ALU_NOP=4'b1111, shared with the decoder;
  - NOP_WORD=32'h00000013;
  - enc_state_t enum {IDLE, RUN, DRAIN}.
- One sub-module: sync_fifo (parameterised WIDTH/DEPTH; push, pop, full, empty, head data), reset async active-low.

Test Plan:
- start; push ADD rd=3 rs1=1 rs2=2, mem_wr_ready=1 -> next cycle mem_wr_en=1, data 0x002081B3, addr 0x0; words_written=1.
- Push SUB rd=5 rs1=6 rs2=7, then ADDI rd=1 rs1=0 imm=0xFFFFFFFF -> writes 0x407302B3 @0x0, then 0xFFF00093 @0x4.
- Push ADDI imm=2048, then SUB with is_imm=1, then alu_op=4'b0001 -> no writes; err pulses x3; err_count=3; push NOP -> 0x00000013 written.
- mem_wr_ready=0, push 5 legal bundles -> in_ready drops after 4th (DEPTH=4), data and enable held. Release ready -> 4 writes at 0x0, 0x4, 0x8, 0xC, then 5th accepted.
- Push 2 bundles, flush with ready=0 -> in_ready=0, busy=1. Raise ready -> 2 writes, then done pulse, state IDLE.
- Push 3 bundles, assert rst_n=0 mid-write -> all outputs at reset values immediately. After release and start, the first write is at BASE_ADDR.
